// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path:
//   - uart_state_e : frame sequencer state encoding
//   - default baud / frame constants used as parameter defaults
//   - uart_parity(): parity of a payload byte, even or odd sense
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_MAX_DATA_BITS    = 8;
  localparam int UART_DEF_CLKS_PER_BIT = 16;
  localparam int UART_DEF_DATA_BITS    = 8;
  localparam int UART_DEF_STOP_BITS    = 1;

  // Parity bit to transmit: XOR of the payload, inverted for odd parity.
  // Callers zero-extend narrower payloads, which leaves the XOR unchanged.
  function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                       input logic                          odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_shift_reg.sv
// -----------------------------------------------------------------------------
// uart_tx_shift_reg
// Parallel-in / serial-out register feeding the UART line, LSB first.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  synchronous active-high reset, clears the register
//   load  in  capture din (wins over shift)
//   shift in  right shift by one, zero fill from the MSB
//   din   in  [WIDTH] parallel data
//   sout  out current bit 0
// -----------------------------------------------------------------------------
module uart_tx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] shreg_r;

  // Shift register: load has priority, shift moves toward bit 0, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r <= {WIDTH{1'b0}};
    end else if (load) begin
      shreg_r <= din;
    end else if (shift) begin
      shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
    end else begin
      shreg_r <= shreg_r;
    end
  end

  assign sout = shreg_r[0];

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit sequencer: takes one byte per valid/ready handshake and sends
// start / data (LSB first) / optional parity / stop bits, CLKS_PER_BIT clocks
// per bit, on a registered line that idles high.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  synchronous active-high reset; aborts a frame without tx_done
//   tx_valid  in  byte offered on tx_data
//   tx_data   in  [DATA_BITS] byte, sampled only on handshake
//   tx_ready  out !tx_busy && !rst
//   tx_serial out registered serial line
//   tx_busy   out frame in progress
//   tx_done   out one-clock pulse in the last clock of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DEF_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = UART_DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                BIT_W     = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > UART_MAX_DATA_BITS)) begin : g_bad_data_bits
    $error("uart_tx_ctrl: DATA_BITS must be 5..8");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  uart_state_e                   state_r, state_next_s;
  logic [BAUD_W-1:0]             baud_cnt_r, baud_next_s;
  logic [BIT_W-1:0]              bit_cnt_r, bit_next_s;
  logic                          stop_cnt_r, stop_next_s;
  logic                          parity_r, parity_next_s;
  logic                          tx_serial_r, serial_next_s;
  logic                          tx_busy_r, tx_done_r, done_next_s;
  logic                          bit_end_s, handshake_s;
  logic                          piso_load_s, piso_shift_s, piso_sout_s;
  logic [UART_MAX_DATA_BITS-1:0] data_ext_s;

  assign tx_ready    = !tx_busy_r && !rst;
  assign handshake_s = tx_valid && tx_ready;
  assign bit_end_s   = (baud_cnt_r == BAUD_LAST);
  assign tx_serial   = tx_serial_r;
  assign tx_busy     = tx_busy_r;
  assign tx_done     = tx_done_r;

  // Zero-extend the payload for the parity helper.
  always_comb begin
    data_ext_s                = {UART_MAX_DATA_BITS{1'b0}};
    data_ext_s[DATA_BITS-1:0] = tx_data;
  end

  // Next-state, counters and next line value. The shifter runs one bit ahead
  // of the line: it also shifts at the end of START, so sout always holds the
  // bit that goes out at the next bit boundary and can be registered there.
  always_comb begin
    state_next_s  = state_r;
    bit_next_s    = bit_cnt_r;
    stop_next_s   = stop_cnt_r;
    parity_next_s = parity_r;
    serial_next_s = tx_serial_r;
    piso_load_s   = 1'b0;
    piso_shift_s  = 1'b0;

    if ((state_r == ST_IDLE) || bit_end_s) begin
      baud_next_s = {BAUD_W{1'b0}};
    end else begin
      baud_next_s = baud_cnt_r + BAUD_W'(1);
    end

    case (state_r)
      ST_IDLE: begin
        if (handshake_s) begin
          state_next_s  = ST_START;
          serial_next_s = 1'b0;
          piso_load_s   = 1'b1;
          parity_next_s = uart_parity(data_ext_s, PAR_ODD);
        end else begin
          serial_next_s = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_next_s  = ST_DATA;
          serial_next_s = piso_sout_s;
          piso_shift_s  = 1'b1;
        end else begin
          state_next_s  = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_cnt_r == BIT_LAST)) begin
          bit_next_s = {BIT_W{1'b0}};
          if (PARITY_EN != 0) begin
            state_next_s  = ST_PARITY;
            serial_next_s = parity_r;
          end else begin
            state_next_s  = ST_STOP;
            serial_next_s = 1'b1;
          end
        end else if (bit_end_s) begin
          bit_next_s    = bit_cnt_r + BIT_W'(1);
          serial_next_s = piso_sout_s;
          piso_shift_s  = 1'b1;
        end else begin
          state_next_s  = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_next_s  = ST_STOP;
          serial_next_s = 1'b1;
        end else begin
          state_next_s  = ST_PARITY;
        end
      end
      ST_STOP: begin
        serial_next_s = 1'b1;
        if (bit_end_s && (stop_cnt_r == STOP_LAST)) begin
          state_next_s = ST_IDLE;
          stop_next_s  = 1'b0;
        end else if (bit_end_s) begin
          stop_next_s  = 1'b1;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s  = ST_IDLE;
        baud_next_s   = {BAUD_W{1'b0}};
        bit_next_s    = {BIT_W{1'b0}};
        stop_next_s   = 1'b0;
        serial_next_s = 1'b1;
      end
    endcase

    // tx_done is registered, so it is raised when the coming clock is the last one.
    done_next_s = (state_next_s == ST_STOP) && (baud_next_s == BAUD_LAST) &&
                  (stop_next_s == STOP_LAST);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      baud_cnt_r  <= {BAUD_W{1'b0}};
      bit_cnt_r   <= {BIT_W{1'b0}};
      stop_cnt_r  <= 1'b0;
      parity_r    <= 1'b0;
      tx_serial_r <= 1'b1;
      tx_busy_r   <= 1'b0;
      tx_done_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      baud_cnt_r  <= baud_next_s;
      bit_cnt_r   <= bit_next_s;
      stop_cnt_r  <= stop_next_s;
      parity_r    <= parity_next_s;
      tx_serial_r <= serial_next_s;
      tx_busy_r   <= (state_next_s != ST_IDLE);
      tx_done_r   <= done_next_s;
    end
  end

  uart_tx_shift_reg #(
    .WIDTH(DATA_BITS)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .load (piso_load_s),
    .shift(piso_shift_s),
    .din  (tx_data),
    .sout (piso_sout_s)
  );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Three transmitter configurations share one stimulus stream:
//   cfg0: no parity, 1 stop   cfg1: even parity, 1 stop   cfg2: odd parity, 2 stops
// A frame-level model (bit list indexed by clock/CLKS_PER_BIT) predicts every
// output each cycle; directed checks pin waveforms against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int              CPB  = 4;
  localparam int              NCFG = 3;
  localparam logic [NCFG-1:0] PE_V = 3'b110;
  localparam logic [NCFG-1:0] PO_V = 3'b100;
  localparam logic [NCFG-1:0] S2_V = 3'b100;

  logic            clk      = 1'b0;
  logic            rst      = 1'b1;
  logic            tx_valid = 1'b0;
  logic [7:0]      tx_data  = 8'h00;
  logic [NCFG-1:0] ready, serial, busy, done;

  int checks = 0;
  int errors = 0;

  logic       smp_rst   = 1'b1;
  logic       smp_valid = 1'b0;
  logic [7:0] smp_data  = 8'h00;

  logic        m_on;
  logic        m_busy[NCFG];
  int          m_t[NCFG];
  int          m_len[NCFG];
  logic [11:0] m_bits[NCFG];

  logic        cap_on[NCFG];
  int          cap_t[NCFG], cap_dones[NCFG], cap_done_at[NCFG];
  logic [11:0] cap_bits[NCFG];
  int          meas_len[NCFG], meas_dones[NCFG], meas_done_at[NCFG];
  logic [11:0] meas_bits[NCFG];
  int          idle_cnt[NCFG], gap_prev[NCFG], done_total[NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    uart_tx_ctrl #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .PARITY_EN   (int'(PE_V[g])),
      .PARITY_ODD  (int'(PO_V[g])),
      .STOP_BITS   (S2_V[g] ? 2 : 1)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (ready[g]),
      .tx_serial(serial[g]),
      .tx_busy  (busy[g]),
      .tx_done  (done[g])
    );
  end

  always #5 clk = ~clk;

  // Inputs as seen by the DUT at each rising edge.
  always @(posedge clk) begin
    smp_rst   <= rst;
    smp_valid <= tx_valid;
    smp_data  <= tx_data;
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Bits of one frame in time order (index 0 = start bit); returns bit count.
  function automatic int frame_bits(input logic [7:0] d, input int i, output logic [11:0] b);
    int n;
    b    = 12'hFFF;
    b[0] = 1'b0;
    n    = 1;
    for (int k = 0; k < 8; k++) begin
      b[n] = d[k];
      n++;
    end
    if (PE_V[i]) begin
      b[n] = (^d) ^ PO_V[i];
      n++;
    end
    n += S2_V[i] ? 2 : 1;
    return n;
  endfunction

  // Model advance, per-cycle comparison and waveform capture.
  initial begin
    m_on = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      m_busy[i] = 1'b0; m_t[i] = 0; m_len[i] = 0; m_bits[i] = 12'h000;
      cap_on[i] = 1'b0; cap_t[i] = 0; cap_dones[i] = 0; cap_done_at[i] = 0; cap_bits[i] = 12'h000;
      meas_len[i] = 0; meas_dones[i] = 0; meas_done_at[i] = 0; meas_bits[i] = 12'h000;
      idle_cnt[i] = 0; gap_prev[i] = 0; done_total[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (smp_rst) m_on = 1'b1;
      for (int i = 0; i < NCFG; i++) begin
        logic exp_serial;
        if (smp_rst) begin
          m_busy[i] = 1'b0;
          m_t[i]    = 0;
        end else if (m_busy[i]) begin
          if (m_t[i] == m_len[i] * CPB - 1) m_busy[i] = 1'b0;
          else m_t[i]++;
        end else if (smp_valid) begin
          m_busy[i] = 1'b1;
          m_t[i]    = 0;
          m_len[i]  = frame_bits(smp_data, i, m_bits[i]);
        end
        if (m_on) begin
          exp_serial = m_busy[i] ? m_bits[i][m_t[i] / CPB] : 1'b1;
          chk($sformatf("cfg%0d serial t=%0t", i, $time), int'(serial[i]), int'(exp_serial));
          chk($sformatf("cfg%0d busy t=%0t", i, $time), int'(busy[i]), int'(m_busy[i]));
          chk($sformatf("cfg%0d done t=%0t", i, $time), int'(done[i]),
              int'(m_busy[i] && (m_t[i] == m_len[i] * CPB - 1)));
          chk($sformatf("cfg%0d ready t=%0t", i, $time), int'(ready[i]), int'(!m_busy[i] && !rst));
          if (done[i]) done_total[i]++;
          if (busy[i]) begin
            if (!cap_on[i]) begin
              cap_on[i] = 1'b1; cap_t[i] = 0; cap_bits[i] = 12'h000;
              cap_dones[i] = 0; cap_done_at[i] = 0; gap_prev[i] = idle_cnt[i];
            end
            if ((cap_t[i] % CPB == 1) && (cap_t[i] / CPB < 12)) cap_bits[i][cap_t[i] / CPB] = serial[i];
            if (done[i]) begin
              cap_dones[i]++;
              cap_done_at[i] = cap_t[i] + 1;
            end
            cap_t[i]++;
            idle_cnt[i] = 0;
          end else begin
            if (cap_on[i]) begin
              cap_on[i] = 1'b0; meas_len[i] = cap_t[i]; meas_bits[i] = cap_bits[i];
              meas_dones[i] = cap_dones[i]; meas_done_at[i] = cap_done_at[i];
            end
            idle_cnt[i]++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while ((busy != 3'b000) && (n < 400)) begin
      tick();
      n++;
    end
    chk("wait_idle all idle", int'(busy == 3'b000), 1);
    repeat (2) tick();
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    int n;
    int total;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset serial", int'(serial), 7);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset ready", int'(ready), 7);

    send(8'hA5);
    wait_idle();
    chk("A5 line bits", int'(meas_bits[0][9:0]), int'(10'b1101001010));
    chk("A5 busy clks", meas_len[0], 40);
    chk("A5 done count", meas_dones[0], 1);
    chk("A5 done clk", meas_done_at[0], 40);

    send(8'h07);
    wait_idle();
    chk("07 even len", meas_len[1], 44);
    chk("07 even parity", int'(meas_bits[1][9]), 1);
    chk("07 odd 2stop len", meas_len[2], 48);
    chk("07 odd parity", int'(meas_bits[2][9]), 0);
    chk("07 odd 2stop done clk", meas_done_at[2], 48);

    tx_valid = 1'b1;
    tx_data  = 8'h55;
    n = 0;
    tick();
    while (!busy[0] && n < 10) begin tick(); n++; end
    tx_data = 8'h0F;
    n = 0;
    while (busy[0] && n < 100) begin tick(); n++; end
    n = 0;
    while (!busy[0] && n < 10) begin tick(); n++; end
    chk("b2b second frame started", int'(busy[0]), 1);
    tx_valid = 1'b0;
    wait_idle();
    chk("b2b idle gap", gap_prev[0], 1);
    chk("b2b 0F line bits", int'(meas_bits[0][9:0]), int'(10'b1000011110));

    send(8'hA5);
    repeat (6) tick();
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    repeat (10) begin
      tx_data = 8'($urandom);
      tick();
    end
    wait_idle();
    chk("midframe A5 line bits", int'(meas_bits[0][9:0]), int'(10'b1101001010));
    chk("midframe busy clks", meas_len[0], 40);

    send(8'hA5);
    repeat (17) tick();
    rst   = 1'b1;
    total = done_total[0];
    tick();
    rst = 1'b0;
    chk("abort serial high", int'(serial[0]), 1);
    chk("abort busy low", int'(busy[0]), 0);
    repeat (8) tick();
    chk("abort no done", done_total[0], total);
    send(8'h3C);
    wait_idle();
    chk("3C line bits", int'(meas_bits[0][9:0]), int'(10'b1001111000));
    chk("3C busy clks", meas_len[0], 40);
    chk("3C done count", meas_dones[0], 1);

    for (int k = 0; k < 800; k++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      rst      = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
